// File: rtl/mem_stage_ctrl.sv
// Memory stage with the MEM/WB pipeline register folded in. Loads and stores
// run over a req/ack word-memory port while the upstream pipeline is frozen.
// A missing ack is bounded by a timeout that completes the access with a
// poison value and raises a sticky error flag.
module mem_stage_ctrl #(
    parameter int unsigned BASE_ADDR = 1024,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_EN_in,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [3:0]        dst_in,
    input  logic [31:0]       ALU_result,
    input  logic [31:0]       Val_Rm,
    output logic              freeze,
    output logic              WB_EN_out,
    output logic              MEM_R_EN_out,
    output logic [3:0]        dst_out,
    output logic [31:0]       ALU_result_out,
    output logic [31:0]       Mem_read_value,
    output logic              mem_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam int unsigned        CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]        POISON  = 32'hDEADBEEF;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      buf_q, buf_d;
    logic             err_q, err_d;
    logic             wb_q, wb_d;
    logic             mr_q, mr_d;
    logic [3:0]       dst_q, dst_d;
    logic [31:0]      alu_q, alu_d;
    logic [31:0]      rd_q, rd_d;

    logic mem_cmd;
    logic is_load;

    // A read+write command is treated as a write, so it never returns load data.
    assign mem_cmd = MEM_R_EN | MEM_W_EN;
    assign is_load = MEM_R_EN & ~MEM_W_EN;

    // Address/data come straight from the (frozen) inputs; only req is gated.
    assign mem_addr  = ADDR_W'((ALU_result - 32'(BASE_ADDR)) >> 2);
    assign mem_wdata = Val_Rm;
    assign mem_we    = MEM_W_EN;
    assign mem_req   = (state_q == S_ACCESS);

    // Stall is raised combinationally in the issuing IDLE cycle; gating with
    // rst makes it drop the instant reset asserts even with a command pending.
    assign freeze = rst & (((state_q == S_IDLE) & mem_cmd) | (state_q == S_ACCESS));

    assign WB_EN_out      = wb_q;
    assign MEM_R_EN_out   = mr_q;
    assign dst_out        = dst_q;
    assign ALU_result_out = alu_q;
    assign Mem_read_value = rd_q;
    assign mem_err        = err_q;

    // Next-state logic for the access FSM and the folded MEM/WB register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        err_d   = err_q;
        wb_d    = wb_q;
        mr_d    = mr_q;
        dst_d   = dst_q;
        alu_d   = alu_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (mem_cmd) begin
                    state_d = S_ACCESS;
                end else begin
                    wb_d  = WB_EN_in;
                    mr_d  = MEM_R_EN;
                    dst_d = dst_in;
                    alu_d = ALU_result;
                    rd_d  = '0;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_ack) begin
                    buf_d   = mem_rdata;
                    state_d = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    buf_d   = POISON;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Always return to IDLE: the upstream advances on this edge,
                // so the same instruction is never seen twice.
                wb_d    = WB_EN_in;
                mr_d    = MEM_R_EN;
                dst_d   = dst_in;
                alu_d   = ALU_result;
                rd_d    = is_load ? buf_q : 32'd0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and pipeline registers; async reset aborts any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
            wb_q    <= 1'b0;
            mr_q    <= 1'b0;
            dst_q   <= '0;
            alu_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
            wb_q    <= wb_d;
            mr_q    <= mr_d;
            dst_q   <= dst_d;
            alu_q   <= alu_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory stage directly downstream of the execute stage, with the MEM/WB pipeline register folded in.
- Consumes the execute stage's ALU result (used as the address), forwarded Rm value (store data), destination register and memory enables.
- Runs each load/store over a request/acknowledge word-memory interface, freezing the upstream pipeline until the access completes.
- Presents registered results to write-back.

Parameters:
BASE_ADDR, 1024, byte address mapped to memory word 0
ADDR_W, 16, word-address width on memory interface
TIMEOUT, 15, max cycles in ACCESS waiting for ack before forced completion

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
WB_EN_in  in  1  write-back enable from EXE/MEM register
MEM_R_EN  in  1  load command
MEM_W_EN  in  1  store command
dst_in  in  4  destination register
ALU_result  in  32  byte address (memory ops) or result (ALU ops)
Val_Rm  in  32  store data
freeze  out  1  stall to all upstream pipeline registers and PC
WB_EN_out  out  1  registered write-back enable
MEM_R_EN_out  out  1  registered load flag (WB mux select)
dst_out  out  4  registered destination
ALU_result_out  out  32  registered ALU result
Mem_read_value  out  32  registered load data
mem_err  out  1  sticky timeout flag
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read; valid while mem_req
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  store data
mem_ack  in  1  one-cycle completion pulse
mem_rdata  in  32  read data, valid with mem_ack

Behaviour:
- Reset (rst=0, async):
  - State IDLE, timeout counter 0.
  - All registered outputs 0, mem_err 0.
  - mem_req deasserts immediately, including mid-access; no completion is reported for an aborted access.
- Address mapping: mem_addr = ((ALU_result - BASE_ADDR) >> 2) truncated to ADDR_W bits.
  - Bits [1:0] ignored.
  - Below-base addresses wrap modulo 2^ADDR_W; no error.
- mem_wdata = Val_Rm.
- mem_we = MEM_W_EN.
- If MEM_R_EN and MEM_W_EN are both set, the access is a write.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No memory command: freeze=0; pipeline register loads inputs every cycle with Mem_read_value <= 0.
  - MEM_R_EN|MEM_W_EN=1: freeze=1 combinationally in the same cycle; pipeline register holds; next state ACCESS.
- ACCESS:
  - mem_req=1, freeze=1.
  - mem_addr/mem_we/mem_wdata stay stable; inputs are frozen upstream.
  - Counter increments each cycle.
  - mem_ack=1: capture mem_rdata into an internal buffer; next state DONE.
  - Counter reaches TIMEOUT with no ack: buffer <= 32'hDEADBEEF; mem_err <= 1 (sticky until reset); next state DONE.
  - mem_ack while not in ACCESS is ignored.
- DONE:
  - mem_req=0, freeze=0.
  - Pipeline register loads WB_EN_in, MEM_R_EN, dst_in and ALU_result.
  - Mem_read_value <= buffer for loads, 0 for stores.
  - Counter cleared; next state IDLE unconditionally. The same instruction still at the inputs must not restart an access.
- Minimum memory-op latency: 3 cycles (IDLE→ACCESS, ack in the first ACCESS cycle, DONE). Each additional ack wait cycle adds 1 cycle.
- Back-to-back memory ops: after DONE, the next instruction arrives and IDLE starts a new access; no request is lost or duplicated.
- Stores: WB_EN_out follows WB_EN_in (0 from decode); mem_rdata is ignored.
- Non-memory instructions never touch mem_* signals (mem_req=0).

Test Plan:
- Load ack after 0 wait: ALU_result=1028, MEM_R_EN=1, mem_ack in the 1st ACCESS cycle with rdata=32'h1234_5678. Required: mem_addr=1; freeze high 2 cycles; Mem_read_value=32'h12345678 and MEM_R_EN_out=1 after DONE.
- Store with 3-cycle ack delay: ALU_result=1032, Val_Rm=32'hCAFE_F00D, MEM_W_EN=1. Required: mem_req high 3 cycles with mem_we=1, mem_addr=2, mem_wdata=32'hCAFEF00D; freeze high 4 cycles; Mem_read_value=0.
- ALU op stream (no memory enables), 10 instructions. Required: freeze never asserts; outputs track inputs with 1-cycle latency; mem_req=0 throughout.
- Timeout with TIMEOUT=15 and no ack. Required: DONE entered after 15 ACCESS cycles; Mem_read_value=32'hDEADBEEF; mem_err=1 and stays 1 across later accesses.
- Reset mid-access: rst=0 asserted asynchronously in the 2nd ACCESS cycle. Required: mem_req, freeze and all outputs drop to 0 without waiting for a clock edge. After release, FSM is in IDLE and a fresh load completes normally.
- Back-to-back load then store, each acked immediately. Required: exactly two mem_req bursts (read then write); no third request from the DONE cycle.
